// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart mtimecmp/msip.
// Define CLINT_TICK_EXT_EN to advance mtime on synchronized rising edges of rtc_tick instead.
module clint_mh #(
   parameter int NHART    = 2,
   parameter int TICK_DIV = 1,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   input  logic [7:0]        req_wstrb,
   output logic              rsp_valid,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   input  logic              rtc_tick,
   output logic [NHART-1:0]  mtime_int,
   output logic [NHART-1:0]  msip_int,
   output logic [63:0]       mtime_data
);

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_e;

   localparam logic [ADDR_W-1:0] CMP_BASE   = ADDR_W'(32'h4000);
   localparam logic [ADDR_W-1:0] MTIME_ADDR = ADDR_W'(32'hBFF8);

   state_e             state_q, state_d;
   logic               req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [63:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic [63:0]        mtime_q, mtime_d;
   logic [63:0]        mtimecmp_q [NHART];
   logic [63:0]        mtimecmp_d [NHART];
   logic [NHART-1:0]   msip_q, msip_d;
   logic [NHART-1:0]   mtime_int_q, mtime_int_d;
   logic [NHART-1:0]   msip_int_q, msip_int_d;

`ifdef CLINT_TICK_EXT_EN
   logic [1:0]         rtc_sync_q, rtc_sync_d;
   logic               rtc_prev_q, rtc_prev_d;
`else
   logic [15:0]        presc_q, presc_d;
   logic               rtc_tick_unused;
   assign rtc_tick_unused = rtc_tick;
`endif

   logic               accept;
   logic               tick;
   logic               mtime_hit;
   logic [NHART-1:0]   cmp_hit;
   logic [NHART-1:0]   msip_hit;
   logic [ADDR_W-1:0]  cmp_off;
   logic [63:0]        rd_data;
   logic               msip_wbit;
   logic               msip_wen;

   function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   always_comb begin
      cmp_off   = req_addr - CMP_BASE;
      mtime_hit = (req_addr == MTIME_ADDR);
      cmp_hit   = '0;
      msip_hit  = '0;
      for (int h = 0; h < NHART; h++) begin
         cmp_hit[h]  = (req_addr >= CMP_BASE) && (cmp_off[2:0] == 3'b000) &&
                       (cmp_off[ADDR_W-1:3] == (ADDR_W-3)'(h));
         msip_hit[h] = (req_addr[1:0] == 2'b00) &&
                       (req_addr[ADDR_W-1:2] == (ADDR_W-2)'(h));
      end
   end

   // msip sits in the upper 32-bit lane when the word offset is odd
   always_comb begin
      rd_data = '0;
      if (mtime_hit) rd_data = mtime_q;
      for (int h = 0; h < NHART; h++) begin
         if (cmp_hit[h]) rd_data = mtimecmp_q[h];
         if (msip_hit[h]) rd_data = req_addr[2] ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
      end
      msip_wbit = req_addr[2] ? req_wdata[32] : req_wdata[0];
      msip_wen  = req_addr[2] ? req_wstrb[4]  : req_wstrb[0];
   end

`ifdef CLINT_TICK_EXT_EN
   always_comb begin
      rtc_sync_d = {rtc_sync_q[0], rtc_tick};
      rtc_prev_d = rtc_sync_q[1];
      tick       = rtc_sync_q[1] & ~rtc_prev_q;
   end
`else
   always_comb begin
      tick    = (presc_q == 16'(TICK_DIV - 1));
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      if (accept && req_wen && mtime_hit) presc_d = 16'd0;
   end
`endif

   always_comb begin
      accept      = (state_q == ST_IDLE) && req_valid;
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d  = mtimecmp_q;
      msip_d      = msip_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d     = ST_RESP;
               req_ready_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rd_data;
               rsp_err_d   = ~(mtime_hit | (|cmp_hit) | (|msip_hit));
            end
         end
         ST_RESP: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
      endcase

      // a software write to mtime overrides the increment of the same cycle
      if (accept && req_wen) begin
         if (mtime_hit) mtime_d = merge_bytes(mtime_q, req_wdata, req_wstrb);
         for (int h = 0; h < NHART; h++) begin
            if (cmp_hit[h]) mtimecmp_d[h] = merge_bytes(mtimecmp_q[h], req_wdata, req_wstrb);
            if (msip_hit[h] && msip_wen) msip_d[h] = msip_wbit;
         end
      end

      for (int h = 0; h < NHART; h++) begin
         mtime_int_d[h] = (mtime_q >= mtimecmp_q[h]);
      end
      msip_int_d = msip_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mtime_q     <= '0;
         for (int h = 0; h < NHART; h++) mtimecmp_q[h] <= '1;
         msip_q      <= '0;
         mtime_int_q <= '0;
         msip_int_q  <= '0;
`ifdef CLINT_TICK_EXT_EN
         rtc_sync_q  <= '0;
         rtc_prev_q  <= 1'b0;
`else
         presc_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         mtime_int_q <= mtime_int_d;
         msip_int_q  <= msip_int_d;
`ifdef CLINT_TICK_EXT_EN
         rtc_sync_q  <= rtc_sync_d;
         rtc_prev_q  <= rtc_prev_d;
`else
         presc_q     <= presc_d;
`endif
      end
   end

   // a reset landing in the response cycle suppresses that response
   assign rsp_valid  = rsp_valid_q & ~reset;
   assign req_ready  = req_ready_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign mtime_int  = mtime_int_q;
   assign msip_int   = msip_int_q;
   assign mtime_data = mtime_q;

endmodule

// File: tb/tb_clint_mh.sv
// Self-checking bench for clint_mh: a register-level model of the CLINT checked every cycle,
// plus directed vectors with hand-computed values; a second instance covers TICK_DIV=4.
module tb_clint_mh;

   localparam int NH   = 2;
   localparam int MDIV = 1;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        rtc_tick;
   logic [NH-1:0] mtime_int;
   logic [NH-1:0] msip_int;
   logic [63:0] mtime_data;

   logic        r4_valid;
   logic        r4_ready;
   logic        r4_wen;
   logic [15:0] r4_addr;
   logic [63:0] r4_wdata;
   logic [7:0]  r4_wstrb;
   logic        r4_rsp_valid;
   logic [63:0] r4_rdata;
   logic        r4_err;
   logic [0:0]  r4_mint;
   logic [0:0]  r4_sint;
   logic [63:0] r4_mtime;

   int  n_assert = 0;
   int  n_fail   = 0;
   bit  chk_en   = 0;

   clint_mh #(.NHART(NH), .TICK_DIV(MDIV), .ADDR_W(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rtc_tick(rtc_tick), .mtime_int(mtime_int), .msip_int(msip_int),
      .mtime_data(mtime_data)
   );

   clint_mh #(.NHART(1), .TICK_DIV(4), .ADDR_W(16)) dut4 (
      .clk(clk), .reset(reset),
      .req_valid(r4_valid), .req_ready(r4_ready), .req_wen(r4_wen),
      .req_addr(r4_addr), .req_wdata(r4_wdata), .req_wstrb(r4_wstrb),
      .rsp_valid(r4_rsp_valid), .rsp_rdata(r4_rdata), .rsp_err(r4_err),
      .rtc_tick(rtc_tick), .mtime_int(r4_mint), .msip_int(r4_sint),
      .mtime_data(r4_mtime)
   );

   // 10 ns core clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // rtc_tick wiggles freely; in the default build it must have no effect
   initial begin
      rtc_tick = 1'b0;
      forever begin
         @(negedge clk);
         rtc_tick = 1'($urandom_range(0, 1));
      end
   end

   // hard stop in case the stimulus ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%h required 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic w, input logic [15:0] a,
                                input logic [63:0] d, input logic [7:0] s);
      req_valid = v;
      req_wen   = w;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
   endtask

   // drive one access from an IDLE negedge; returns at the negedge of the response cycle
   task automatic doAccess(input logic w, input logic [15:0] a, input logic [63:0] d,
                           input logic [7:0] s);
      applyStimulus(1'b1, w, a, d, s);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Register-level model: the CLINT as a set of architectural registers
   logic [63:0] m_mtime;
   logic [63:0] m_cmp [NH];
   bit          m_msip [NH];
   bit [NH-1:0] m_tint;
   bit [NH-1:0] m_sint;
   int          m_cnt;
   bit          m_pend;
   logic [63:0] m_rdata;
   bit          m_err;
   logic [63:0] m_next;
   int          m_ncnt;
   int          m_kind;
   int          m_idx;

   function automatic logic [63:0] byteMerge(input logic [63:0] o, input logic [63:0] n,
                                             input logic [7:0] s);
      logic [63:0] r = o;
      for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
   function automatic int regionOf(input logic [15:0] a, output int idx);
      idx = 0;
      if (a == 16'hBFF8) return 3;
      if (a >= 16'h4000 && a < 16'h4000 + 16'(8 * NH) && a % 8 == 0) begin
         idx = int'(a - 16'h4000) / 8;
         return 2;
      end
      if (a < 16'(4 * NH) && a % 4 == 0) begin
         idx = int'(a) / 4;
         return 1;
      end
      return 0;
   endfunction

   // The model advances on each rising edge from the values held before that edge
   always @(posedge clk) begin
      if (reset) begin
         m_mtime = 64'd0;
         m_cnt   = 0;
         for (int h = 0; h < NH; h++) begin
            m_cmp[h]  = '1;
            m_msip[h] = 1'b0;
         end
         m_tint  = '0;
         m_sint  = '0;
         m_pend  = 1'b0;
         m_rdata = 64'd0;
         m_err   = 1'b0;
      end else begin
         for (int h = 0; h < NH; h++) begin
            m_tint[h] = (m_mtime >= m_cmp[h]);
            m_sint[h] = m_msip[h];
         end
         if (m_cnt == MDIV - 1) begin
            m_next = m_mtime + 64'd1;
            m_ncnt = 0;
         end else begin
            m_next = m_mtime;
            m_ncnt = m_cnt + 1;
         end
         if (req_valid && !m_pend) begin
            m_kind = regionOf(req_addr, m_idx);
            m_err  = (m_kind == 0);
            case (m_kind)
               1: m_rdata = 64'(m_msip[m_idx]) << (req_addr[2] ? 32 : 0);
               2: m_rdata = m_cmp[m_idx];
               3: m_rdata = m_mtime;
               default: m_rdata = 64'd0;
            endcase
            if (req_wen) begin
               case (m_kind)
                  1: if (req_wstrb[req_addr[2] ? 4 : 0]) m_msip[m_idx] = req_wdata[req_addr[2] ? 32 : 0];
                  2: m_cmp[m_idx] = byteMerge(m_cmp[m_idx], req_wdata, req_wstrb);
                  3: begin
                     m_next = byteMerge(m_mtime, req_wdata, req_wstrb);
                     m_ncnt = 0;
                  end
                  default: ;
               endcase
            end
            m_pend = 1'b1;
         end else begin
            m_pend = 1'b0;
         end
         m_mtime = m_next;
         m_cnt   = m_ncnt;
      end
   end

   // Compare the main instance with the model on every cycle, away from the clock edge
   always begin
      @(negedge clk);
      #1;
      if (chk_en) begin
         checkOutput("mdl_mtime_data", mtime_data, m_mtime);
         checkOutput("mdl_mtime_int", 64'(mtime_int), 64'(m_tint));
         checkOutput("mdl_msip_int", 64'(msip_int), 64'(m_sint));
         checkOutput("mdl_req_ready", 64'(req_ready), 64'(!m_pend));
         checkOutput("mdl_rsp_valid", 64'(rsp_valid), 64'(m_pend && !reset));
         if (m_pend && !reset) begin
            checkOutput("mdl_rsp_rdata", rsp_rdata, m_rdata);
            checkOutput("mdl_rsp_err", 64'(rsp_err), 64'(m_err));
         end
      end
   end

   // Directed sequence with hand-computed literal expectations
   initial begin
      bit found;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 8'h0);
      r4_valid = 1'b0; r4_wen = 1'b0; r4_addr = 16'h0; r4_wdata = 64'h0; r4_wstrb = 8'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;

      checkOutput("rst_mtime_int", 64'(mtime_int), 64'h0);
      checkOutput("rst_msip_int", 64'(msip_int), 64'h0);
      checkOutput("rst_req_ready", 64'(req_ready), 64'h1);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 64'h0);
      checkOutput("rst_rsp_err", 64'(rsp_err), 64'h0);

      // mtime counts every cycle here; the TICK_DIV=4 instance every fourth cycle
      for (int n = 0; n <= 9; n++) begin
         if (n <= 2) checkOutput("div1_mtime_seq", mtime_data, 64'(n));
         case (n)
            0: begin
               checkOutput("div4_mtime_rst", r4_mtime, 64'd0);
               checkOutput("div4_ready_rst", 64'(r4_ready), 64'h1);
            end
            3: checkOutput("div4_mtime_c3", r4_mtime, 64'd0);
            4: checkOutput("div4_mtime_c4", r4_mtime, 64'd1);
            7: begin
               checkOutput("div4_mtime_c7", r4_mtime, 64'd1);
               r4_valid = 1'b1; r4_wen = 1'b0; r4_addr = 16'hBFF8;
            end
            8: begin
               checkOutput("div4_mtime_c8", r4_mtime, 64'd2);
               checkOutput("div4_rsp_valid", 64'(r4_rsp_valid), 64'h1);
               checkOutput("div4_rd_preedge", r4_rdata, 64'd1);
               r4_valid = 1'b0;
            end
            9: checkOutput("div4_rsp_once", 64'(r4_rsp_valid), 64'h0);
            default: ;
         endcase
         @(negedge clk);
      end

      // timer interrupt for hart 1 at mtimecmp = 0x10
      doAccess(1'b1, 16'hBFF8, 64'h0, 8'hFF);
      checkOutput("mtime_wr_zero", mtime_data, 64'h0);
      @(negedge clk);
      doAccess(1'b1, 16'h4008, 64'h10, 8'hFF);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mtime_data == 64'h10) found = 1'b1;
         else @(negedge clk);
      end
      checkOutput("wait_mtime_10", 64'(found), 64'h1);
      checkOutput("tint_before", 64'(mtime_int), 64'h0);
      @(negedge clk);
      checkOutput("tint_after", 64'(mtime_int), 64'h2);

      // byte-strobed write to mtimecmp[0], then read back
      doAccess(1'b1, 16'h4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
      @(negedge clk);
      doAccess(1'b0, 16'h4000, 64'h0, 8'h0);
      checkOutput("cmp0_partial", rsp_rdata, 64'hFFFF_FFFF_CCCC_DDDD);
      @(negedge clk);
      doAccess(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      @(negedge clk);

      // write on a tick cycle wins, then FF, then wrap to 0
      doAccess(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      checkOutput("wrap_fe", mtime_data, 64'hFFFF_FFFF_FFFF_FFFE);
      @(negedge clk);
      checkOutput("wrap_ff", mtime_data, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      checkOutput("wrap_zero", mtime_data, 64'h0);
      checkOutput("wrap_tint0", 64'(mtime_int[0]), 64'h1);

      // software interrupt for hart 1 through the upper lane
      doAccess(1'b1, 16'h0004, 64'h1_0000_0000, 8'h10);
      checkOutput("msip_lag", 64'(msip_int), 64'h0);
      @(negedge clk);
      checkOutput("msip_set", 64'(msip_int), 64'h2);
      doAccess(1'b0, 16'h0004, 64'h0, 8'h0);
      checkOutput("msip_read", rsp_rdata, 64'h1_0000_0000);
      @(negedge clk);
      doAccess(1'b1, 16'h0004, 64'h0, 8'h10);
      @(negedge clk);
      checkOutput("msip_clear", 64'(msip_int), 64'h0);

      // unmapped read held valid back-to-back
      applyStimulus(1'b1, 1'b0, 16'h8000, 64'h0, 8'h0);
      @(negedge clk);
      checkOutput("unmap_err", 64'(rsp_err), 64'h1);
      checkOutput("unmap_rdata", rsp_rdata, 64'h0);
      checkOutput("b2b_not_ready", 64'(req_ready), 64'h0);
      applyStimulus(1'b1, 1'b0, 16'hBFF8, 64'h0, 8'h0);
      @(negedge clk);
      checkOutput("b2b_idle_ready", 64'(req_ready), 64'h1);
      checkOutput("b2b_no_rsp", 64'(rsp_valid), 64'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("b2b_second_rsp", 64'(rsp_valid), 64'h1);
      checkOutput("b2b_second_err", 64'(rsp_err), 64'h0);
      @(negedge clk);

      // reset in the response cycle drops the response
      applyStimulus(1'b1, 1'b0, 16'hBFF8, 64'h0, 8'h0);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      checkOutput("rst_drop_rsp", 64'(rsp_valid), 64'h0);
      @(negedge clk);
      checkOutput("rst_after_rsp", 64'(rsp_valid), 64'h0);
      checkOutput("rst_after_ready", 64'(req_ready), 64'h1);
      checkOutput("rst_after_mtime", mtime_data, 64'h0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_restart", mtime_data, 64'h1);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
